calc_entry_sequencer: RTL

//  Front-end controller of the integer calculator. Turns keypad presses (10 digit keys, 8 function keys) into signed

---
 rtl/calc_pkg.sv | 44 ++++
 rtl/calc_entry_sequencer_if.sv | 31 +++
 rtl/calc_key_edge.sv | 84 ++++++++
 rtl/calc_entry_sequencer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : calc_pkg
// Purpose  : Shared encodings for the calculator entry sequencer: ALU opcode
//            values (plus an internal "no operation pending" code), function
//            key bit indices and FSM state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package calc_pkg;

    // Opcodes are 3 bits wide so OP_NONE can sit outside the 2-bit ALU range.
    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_MUL  = 3'd2;
    localparam logic [2:0] OP_DIV  = 3'd3;
    localparam logic [2:0] OP_NONE = 3'd4;

    // Function key bit positions on key_fn.
    localparam logic [2:0] FN_CLEAR  = 3'd0;
    localparam logic [2:0] FN_ADD    = 3'd1;
    localparam logic [2:0] FN_SUB    = 3'd2;
    localparam logic [2:0] FN_MUL    = 3'd3;
    localparam logic [2:0] FN_DIV    = 3'd4;
    localparam logic [2:0] FN_NEG    = 3'd5;
    localparam logic [2:0] FN_RSVD   = 3'd6;
    localparam logic [2:0] FN_EQUALS = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ENTRY   = 3'd1,
        S_OP_PEND = 3'd2,
        S_EXEC    = 3'd3,
        S_RESULT  = 3'd4,
        S_ERROR   = 3'd5
    } state_e;

    // Operator keys ADD..DIV sit on consecutive bits 1..4, so the opcode is
    // simply the key index minus one.
    function automatic logic [2:0] fn_to_op(input logic [2:0] idx);
        return idx - 3'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/calc_entry_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : calc_entry_sequencer_if
// Purpose  : req/ack handshake between the entry sequencer and the shared ALU.
// Ports    : alu_req/op/a/b  sequencer -> ALU, held until ack
//            alu_ack/result/err  ALU -> sequencer, valid in the ack cycle
//            master = sequencer side, slave = ALU side
// Revision : 1.0 - initial release
// ============================================================================
interface calc_entry_sequencer_if #(
    parameter int WIDTH = 32
);
    logic                    alu_req;
    logic [1:0]              alu_op;
    logic signed [WIDTH-1:0] alu_a;
    logic signed [WIDTH-1:0] alu_b;
    logic                    alu_ack;
    logic signed [WIDTH-1:0] alu_result;
    logic                    alu_err;

    modport master (
        output alu_req, alu_op, alu_a, alu_b,
        input  alu_ack, alu_result, alu_err
    );

    modport slave (
        input  alu_req, alu_op, alu_a, alu_b,
        output alu_ack, alu_result, alu_err
    );
endinterface
`default_nettype wire

// File: rtl/calc_key_edge.sv
`default_nettype none
// ============================================================================
// Module   : calc_key_edge
// Purpose  : 2-FF synchroniser and rising-edge detect for the 18 keypad
//            switches. Emits a registered one-cycle press pulse; a cycle with
//            more than one simultaneous press is discarded entirely.
// Ports    : clk, rst              clock, async active-high reset
//            key_dig[9:0]          raw digit switches
//            key_fn[7:0]           raw function switches
//            dig_vld, dig_val[3:0] single digit press and its value
//            fn_vld, fn_idx[2:0]   single function press and its bit index
// Revision : 1.0 - initial release
// ============================================================================
module calc_key_edge (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic [9:0] key_dig,
    input  wire logic [7:0] key_fn,
    output logic            dig_vld,
    output logic [3:0]      dig_val,
    output logic            fn_vld,
    output logic [2:0]      fn_idx
);
    // Bits 0..9 are digits, bits 10..17 function keys.
    logic [17:0] sync1_q, sync2_q, prev_q;
    logic [17:0] press;
    logic [4:0]  npress;
    logic        dig_vld_d, fn_vld_d, dig_vld_q, fn_vld_q;
    logic [3:0]  dig_val_d, dig_val_q;
    logic [2:0]  fn_idx_d, fn_idx_q;

    always_comb begin
        press     = sync2_q & ~prev_q;
        npress    = '0;
        dig_vld_d = 1'b0;
        fn_vld_d  = 1'b0;
        dig_val_d = '0;
        fn_idx_d  = '0;
        for (int i = 0; i < 18; i++) begin
            npress = npress + {4'd0, press[i]};
        end
        for (int i = 0; i < 10; i++) begin
            if (press[i]) begin
                dig_val_d = 4'(i);
            end
        end
        for (int i = 0; i < 8; i++) begin
            if (press[10+i]) begin
                fn_idx_d = 3'(i);
            end
        end
        // Only an unambiguous single press is forwarded.
        if (npress == 5'd1) begin
            dig_vld_d = |press[9:0];
            fn_vld_d  = |press[17:10];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            prev_q    <= '0;
            dig_vld_q <= 1'b0;
            fn_vld_q  <= 1'b0;
            dig_val_q <= '0;
            fn_idx_q  <= '0;
        end else begin
            sync1_q   <= {key_fn, key_dig};
            sync2_q   <= sync1_q;
            prev_q    <= sync2_q;
            dig_vld_q <= dig_vld_d;
            fn_vld_q  <= fn_vld_d;
            dig_val_q <= dig_val_d;
            fn_idx_q  <= fn_idx_d;
        end
    end

    assign dig_vld = dig_vld_q;
    assign dig_val = dig_val_q;
    assign fn_vld  = fn_vld_q;
    assign fn_idx  = fn_idx_q;
endmodule
`default_nettype wire

// File: rtl/calc_entry_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : calc_entry_sequencer
// Purpose  : Calculator front end. Builds signed operands from digit presses,
//            chains pending operations through the shared ALU and drives the
//            display value / error flag.
// Ports    : clk, rst            clock, async active-high reset
//            key_dig, key_fn     raw keypad switches (level)
//            alu                 ALU handshake (master side)
//            disp_val, disp_err  registered display value and error flag
//            busy                ALU transaction outstanding
// Revision : 1.0 - initial release
// ============================================================================
module calc_entry_sequencer
    import calc_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MAX_DIGITS = 9,
    parameter int ALU_TMO    = 255
) (
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic [9:0]         key_dig,
    input  wire logic [7:0]         key_fn,
    calc_entry_sequencer_if.master  alu,
    output logic signed [WIDTH-1:0] disp_val,
    output logic                    disp_err,
    output logic                    busy
);
    localparam int TMO_W  = $clog2(ALU_TMO + 1);
    localparam int NDIG_W = $clog2(MAX_DIGITS + 1);

    // Reset asserts asynchronously but is released on a clock edge.
    logic [1:0] rst_sync_q;
    logic       rst_int;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rst_sync_q <= 2'b11;
        else     rst_sync_q <= {rst_sync_q[0], 1'b0};
    end
    assign rst_int = rst_sync_q[1];

    logic       dig_vld, fn_vld;
    logic [3:0] dig_val;
    logic [2:0] fn_idx;

    calc_key_edge u_key_edge (
        .clk     (clk),
        .rst     (rst_int),
        .key_dig (key_dig),
        .key_fn  (key_fn),
        .dig_vld (dig_vld),
        .dig_val (dig_val),
        .fn_vld  (fn_vld),
        .fn_idx  (fn_idx)
    );

    state_e                  state_q, state_d;
    logic signed [WIDTH-1:0] acc_q, acc_d, a_reg_q, a_reg_d;
    logic [NDIG_W-1:0]       ndig_q, ndig_d;
    logic [2:0]              pend_op_q, pend_op_d;
    logic [2:0]              next_op_q, next_op_d;   // pend_op after ack; NONE -> RESULT
    logic                    alu_req_q, alu_req_d;
    logic [1:0]              alu_op_q, alu_op_d;
    logic signed [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [TMO_W-1:0]        tmo_q, tmo_d;
    logic signed [WIDTH-1:0] disp_val_q, disp_val_d;
    logic                    disp_err_q, disp_err_d;

    logic signed [WIDTH-1:0] dig_ext, acc_x10, acc_append, issue_b;
    logic                    issue, fn_is_op;
    logic [2:0]              key_op, issue_next;

    assign dig_ext    = {{(WIDTH-4){1'b0}}, dig_val};
    assign acc_x10    = (acc_q <<< 3) + (acc_q <<< 1);
    // Negative operands grow away from zero so the sign survives entry.
    assign acc_append = acc_q[WIDTH-1] ? (acc_x10 - dig_ext) : (acc_x10 + dig_ext);
    assign fn_is_op   = (fn_idx >= FN_ADD) && (fn_idx <= FN_DIV);
    assign key_op     = fn_to_op(fn_idx);

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        ndig_d     = ndig_q;
        a_reg_d    = a_reg_q;
        pend_op_d  = pend_op_q;
        next_op_d  = next_op_q;
        alu_req_d  = alu_req_q;
        alu_op_d   = alu_op_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        tmo_d      = tmo_q;
        issue      = 1'b0;
        issue_b    = acc_q;
        issue_next = OP_NONE;

        if (fn_vld && fn_idx == FN_CLEAR) begin
            state_d   = S_IDLE;
            acc_d     = '0;
            ndig_d    = '0;
            a_reg_d   = '0;
            pend_op_d = OP_NONE;
            next_op_d = OP_NONE;
            alu_req_d = 1'b0;
            tmo_d     = '0;
        end else begin
            unique case (state_q)
                S_EXEC: begin
                    if (alu_req_q && alu.alu_ack) begin
                        alu_req_d = 1'b0;
                        if (alu.alu_err) begin
                            state_d = S_ERROR;
                        end else begin
                            a_reg_d   = alu.alu_result;
                            pend_op_d = next_op_q;
                            state_d   = (next_op_q == OP_NONE) ? S_RESULT : S_OP_PEND;
                        end
                    end else if (tmo_q == TMO_W'(ALU_TMO - 1)) begin
                        alu_req_d = 1'b0;
                        state_d   = S_ERROR;
                    end else begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
                end
                S_ERROR: ;
                default: begin
                    if (dig_vld) begin
                        if (state_q == S_ENTRY) begin
                            // Leading zeros are not counted as digits.
                            if (ndig_q < NDIG_W'(MAX_DIGITS) && !(acc_q == '0 && dig_val == 4'd0)) begin
                                acc_d  = acc_append;
                                ndig_d = ndig_q + NDIG_W'(1);
                            end
                        end else begin
                            acc_d   = dig_ext;
                            ndig_d  = (dig_val == 4'd0) ? NDIG_W'(0) : NDIG_W'(1);
                            state_d = S_ENTRY;
                            if (state_q == S_RESULT) pend_op_d = OP_NONE;
                        end
                    end else if (fn_vld && fn_is_op) begin
                        if (state_q == S_ENTRY && pend_op_q != OP_NONE) begin
                            issue      = 1'b1;
                            issue_b    = acc_q;
                            issue_next = key_op;
                        end else begin
                            if (state_q == S_ENTRY) a_reg_d = acc_q;
                            if (state_q == S_IDLE)  a_reg_d = '0;
                            pend_op_d = key_op;
                            state_d   = S_OP_PEND;
                        end
                    end else if (fn_vld && fn_idx == FN_NEG) begin
                        if (state_q == S_ENTRY)  acc_d   = -acc_q;
                        if (state_q == S_RESULT) a_reg_d = -a_reg_q;
                    end else if (fn_vld && fn_idx == FN_EQUALS) begin
                        if (state_q == S_ENTRY) begin
                            if (pend_op_q == OP_NONE) begin
                                a_reg_d = acc_q;
                                state_d = S_RESULT;
                            end else begin
                                issue   = 1'b1;
                                issue_b = acc_q;
                            end
                        end else if (state_q == S_OP_PEND) begin
                            issue   = 1'b1;
                            issue_b = a_reg_q;
                        end
                    end
                end
            endcase
        end

        if (issue) begin
            state_d   = S_EXEC;
            alu_req_d = 1'b1;
            alu_op_d  = pend_op_q[1:0];
            alu_a_d   = a_reg_q;
            alu_b_d   = issue_b;
            next_op_d = issue_next;
            tmo_d     = '0;
        end

        disp_err_d = (state_d == S_ERROR);
        unique case (state_d)
            S_ENTRY:                     disp_val_d = acc_d;
            S_OP_PEND, S_RESULT, S_EXEC: disp_val_d = a_reg_d;
            default:                     disp_val_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst_int) begin
        if (rst_int) begin
            state_q    <= S_IDLE;
            acc_q      <= '0;
            ndig_q     <= '0;
            a_reg_q    <= '0;
            pend_op_q  <= OP_NONE;
            next_op_q  <= OP_NONE;
            alu_req_q  <= 1'b0;
            alu_op_q   <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            tmo_q      <= '0;
            disp_val_q <= '0;
            disp_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            ndig_q     <= ndig_d;
            a_reg_q    <= a_reg_d;
            pend_op_q  <= pend_op_d;
            next_op_q  <= next_op_d;
            alu_req_q  <= alu_req_d;
            alu_op_q   <= alu_op_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            tmo_q      <= tmo_d;
            disp_val_q <= disp_val_d;
            disp_err_q <= disp_err_d;
        end
    end

    assign alu.alu_req = alu_req_q;
    assign alu.alu_op  = alu_op_q;
    assign alu.alu_a   = alu_a_q;
    assign alu.alu_b   = alu_b_q;
    assign disp_val    = disp_val_q;
    assign disp_err    = disp_err_q;
    assign busy        = (state_q == S_EXEC);
endmodule
`default_nettype wire
